// File: rtl/seg_pkg.sv
// Shared constants, types and helpers for the seven-segment scan controller.
package seg_pkg;

  localparam int unsigned NUM_DIG = 4;
  localparam int unsigned IDX_W   = 2;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low g..a patterns, bit 7 (dp) off; index 0 is the last element.
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  typedef enum logic {PhBlank, PhShow} phase_e;

  function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_DIG-1:0] mask);
    lowest_set = '0;
    for (int i = NUM_DIG - 1; i >= 0; i--) begin
      if (mask[i]) lowest_set = IDX_W'(i);
    end
  endfunction

  // Next set bit above idx, circularly; returns idx itself when it is the only one or mask==0.
  function automatic logic [IDX_W-1:0] next_set(input logic [NUM_DIG-1:0] mask,
                                                 input logic [IDX_W-1:0]   idx);
    next_set = idx;
    for (int k = NUM_DIG; k >= 1; k--) begin
      if (mask[idx + IDX_W'(k)]) next_set = idx + IDX_W'(k);
    end
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Image-load handshake between the datapath (master) and the scan controller (slave).
interface seg_scan_ctrl_if;
  import seg_pkg::*;

  logic                 load_valid;
  logic                 load_ready;
  logic [4*NUM_DIG-1:0] load_hex;
  logic [NUM_DIG-1:0]   load_dp;
  logic [NUM_DIG-1:0]   load_en;

  modport master (
    output load_valid, load_hex, load_dp, load_en,
    input  load_ready
  );

  modport slave (
    input  load_valid, load_hex, load_dp, load_en,
    output load_ready
  );
endinterface

// File: rtl/seg_decode.sv
// Combinational nibble + decimal point to active-low segment pattern.
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] seg
);

  assign seg = {~dp, SEG_TABLE[nibble][6:0]};

endmodule

// File: rtl/seg_scan_ctrl.sv
// Round-robin 4-digit common-anode scan with blanking and a frame-synchronous image buffer.
// Optional LEAD_ZERO_BLANK_EN blanks leading zero digits (3..1) during SHOW.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 500,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  seg_scan_ctrl_if.slave      load_if,
  output logic [NUM_DIG-1:0]  sel,
  output logic [7:0]          data,
  output logic                frame_tick
);

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d, idx_nxt;
  logic [4*NUM_DIG-1:0] hex_q, hex_d, pend_hex_q, pend_hex_d;
  logic [NUM_DIG-1:0]   dp_q, dp_d, pend_dp_q, pend_dp_d;
  logic [NUM_DIG-1:0]   en_q, en_d, pend_en_q, pend_en_d;
  logic                 pend_full_q, pend_full_d;
  logic [NUM_DIG-1:0]   sel_q, sel_d;
  logic [7:0]           data_q, data_d;
  logic                 tick_q, tick_d;

  logic                 wrap, boundary, accept, show, lz_blank;
  phase_e               phase_d;
  logic [3:0]           nib;
  logic                 dp_bit;
  logic [7:0]           dec_seg;

  assign wrap     = (cnt_q == CNT_W'(SCAN_DIV - 1));
  assign idx_nxt  = next_set(en_q, idx_q);
  // Wrapping back to (or staying on) an index not above the current one closes the frame.
  assign boundary = wrap && (idx_nxt <= idx_q);
  assign accept   = load_if.load_valid && !pend_full_q;

  assign load_if.load_ready = !pend_full_q;

  always_comb begin
    cnt_d       = wrap ? '0 : cnt_q + CNT_W'(1);
    idx_d       = idx_q;
    hex_d       = hex_q;
    dp_d        = dp_q;
    en_d        = en_q;
    pend_hex_d  = pend_hex_q;
    pend_dp_d   = pend_dp_q;
    pend_en_d   = pend_en_q;
    pend_full_d = pend_full_q;

    if (boundary && pend_full_q) begin
      hex_d       = pend_hex_q;
      dp_d        = pend_dp_q;
      en_d        = pend_en_q;
      idx_d       = lowest_set(pend_en_q);
      pend_full_d = 1'b0;
    end else if (wrap) begin
      idx_d = idx_nxt;
    end

    // accept implies pending was empty, so it never collides with the swap above
    if (accept) begin
      pend_hex_d  = load_if.load_hex;
      pend_dp_d   = load_if.load_dp;
      pend_en_d   = load_if.load_en;
      pend_full_d = 1'b1;
    end
  end

  // Outputs are computed from next state so they line up with cnt/idx without extra delay.
  assign phase_d = (cnt_d < CNT_W'(BLANK_CYC)) ? PhBlank : PhShow;
  assign nib     = hex_d[{idx_d, 2'b00} +: 4];
  assign dp_bit  = dp_d[idx_d];
  assign show    = (phase_d == PhShow) && en_d[idx_d];

  seg_decode u_decode (
    .nibble (nib),
    .dp     (dp_bit),
    .seg    (dec_seg)
  );

`ifdef LEAD_ZERO_BLANK_EN
  always_comb begin
    lz_blank = 1'b0;
    if ((idx_d != '0) && (nib == 4'h0)) begin
      lz_blank = 1'b1;
      for (int j = 1; j < NUM_DIG; j++) begin
        if ((j > int'(idx_d)) && en_d[j] && (hex_d[j*4 +: 4] != 4'h0)) lz_blank = 1'b0;
      end
    end
  end
`else
  assign lz_blank = 1'b0;
`endif

  always_comb begin
    sel_d  = '1;
    data_d = SEG_BLANK;
    tick_d = boundary;
    if (show) begin
      sel_d  = ~(NUM_DIG'(1) << idx_d);
      data_d = lz_blank ? {~dp_bit, 7'h7F} : dec_seg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      hex_q       <= '0;
      dp_q        <= '0;
      en_q        <= '0;
      pend_hex_q  <= '0;
      pend_dp_q   <= '0;
      pend_en_q   <= '0;
      pend_full_q <= 1'b0;
      sel_q       <= '1;
      data_q      <= SEG_BLANK;
      tick_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      hex_q       <= hex_d;
      dp_q        <= dp_d;
      en_q        <= en_d;
      pend_hex_q  <= pend_hex_d;
      pend_dp_q   <= pend_dp_d;
      pend_en_q   <= pend_en_d;
      pend_full_q <= pend_full_d;
      sel_q       <= sel_d;
      data_q      <= data_d;
      tick_q      <= tick_d;
    end
  end

  assign sel        = sel_q;
  assign data       = data_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: frame model pushes expected digits, monitor pops per slot.
module tb_seg_scan_ctrl;

  localparam int unsigned SCAN_DIV  = 8;
  localparam int unsigned BLANK_CYC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sel;
  logic [7:0] data;
  logic       frame_tick;

  seg_scan_ctrl_if lif ();

  seg_scan_ctrl #(
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC),
    .CNT_W     (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_if    (lif),
    .sel        (sel),
    .data       (data),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] seg_ref [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  logic [11:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] exp_seg(input logic [15:0] h, input logic [3:0] d,
                                         input logic [3:0] e, input int i);
    logic [3:0] n;
    logic       lz;
    n  = h[i*4 +: 4];
    lz = 1'b0;
`ifdef LEAD_ZERO_BLANK_EN
    if (i > 0 && n == 4'h0) begin
      lz = 1'b1;
      for (int j = i + 1; j < 4; j++) if (e[j] && h[j*4 +: 4] != 4'h0) lz = 1'b0;
    end
`else
    if (e == 4'h0) lz = 1'b0;
`endif
    return lz ? {~d[i], 7'h7F} : {~d[i], seg_ref[n][6:0]};
  endfunction

  // Frame-level model: active/pending image, load_ready, frame period.
  logic [15:0] m_hex, p_hex;
  logic [3:0]  m_dp, m_en, p_dp, p_en;
  bit          p_full;
  int          m_cyc;

  always @(negedge clk) begin
    if (rst) begin
      m_hex = '0; m_dp = '0; m_en = '0;
      p_hex = '0; p_dp = '0; p_en = '0; p_full = 1'b0;
      m_cyc = 0;
      exp_q.delete();
    end else begin
      if (frame_tick) begin
        check("frame_period", m_cyc, SCAN_DIV * ((m_en == 4'h0) ? 1 : $countones(m_en)));
        if (p_full) begin
          m_hex = p_hex; m_dp = p_dp; m_en = p_en; p_full = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
          if (m_en[i]) exp_q.push_back({4'(~(4'b0001 << i)), exp_seg(m_hex, m_dp, m_en, i)});
        end
        m_cyc = 1;
      end else begin
        m_cyc++;
      end
      check("load_ready", lif.load_ready, !p_full);
      if (lif.load_valid && !p_full) begin
        p_hex = lif.load_hex; p_dp = lif.load_dp; p_en = lif.load_en; p_full = 1'b1;
      end
    end
  end

  // Monitor: one pop per SHOW run; also checks run lengths and blank data.
  logic [11:0] run_val, cur, exp_v;
  int          run_len;
  bit          run_vld;

  always @(negedge clk) begin
    if (rst) begin
      run_vld = 1'b0;
    end else begin
      cur = {sel, data};
      if (!run_vld) begin
        run_val = cur; run_len = 1; run_vld = 1'b1;
      end else if (cur == run_val) begin
        run_len++;
      end else begin
        if (run_val[11:8] != 4'hF) check("show_len", run_len, SCAN_DIV - BLANK_CYC);
        else                       check("blank_data", run_val[7:0], 8'hFF);
        if (cur[11:8] != 4'hF) begin
          if (run_val[11:8] == 4'hF) check("blank_len", run_len % SCAN_DIV, BLANK_CYC);
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL digit: unexpected sel=%h data=%h, none expected", cur[11:8], cur[7:0]);
          end else begin
            exp_v = exp_q.pop_front();
            check("digit", cur, exp_v);
          end
        end
        run_val = cur; run_len = 1;
      end
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_sel"},   sel, 4'hF);
    check({tag, "_data"},  data, 8'hFF);
    check({tag, "_tick"},  frame_tick, 1'b0);
    check({tag, "_ready"}, lif.load_ready, 1'b1);
  endtask

  task automatic wait_ticks(input int n);
    int seen = 0;
    for (int c = 0; c < 64 * SCAN_DIV && seen < n; c++) begin
      @(negedge clk);
      if (frame_tick) seen++;
    end
    if (seen < n) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_ticks: saw %0d ticks, required %0d", seen, n);
    end
    @(posedge clk); #1;
  endtask

  task automatic load(input logic [15:0] h, input logic [3:0] d, input logic [3:0] e,
                      output bit on_tick);
    bit done = 1'b0;
    on_tick = 1'b0;
    lif.load_valid = 1'b1;
    lif.load_hex   = h;
    lif.load_dp    = d;
    lif.load_en    = e;
    for (int i = 0; i < 64 * SCAN_DIV && !done; i++) begin
      @(negedge clk);
      if (lif.load_ready) begin
        done    = 1'b1;
        on_tick = frame_tick;
      end
      @(posedge clk); #1;
    end
    lif.load_valid = 1'b0;
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL load_timeout: got no ready, expected accept of %h", h);
    end
  endtask

  initial begin
    bit on_tick;
    bit found;
    lif.load_valid = 1'b0;
    lif.load_hex   = '0;
    lif.load_dp    = '0;
    lif.load_en    = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("rst");
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_reset("post_rst");
    @(posedge clk); #1;
    wait_ticks(2);

    load(16'h1234, 4'b0000, 4'b1111, on_tick);
    wait_ticks(3);
    load(16'hABCD, 4'b0001, 4'b0101, on_tick);
    wait_ticks(3);

    // back-to-back: second image must stall until the boundary that consumes the first
    load(16'h5678, 4'b0000, 4'b1111, on_tick);
    load(16'h9EF0, 4'b1000, 4'b0110, on_tick);
    check("b2b_on_tick", on_tick, 1'b1);
    wait_ticks(3);

    load(16'h0070, 4'b0000, 4'b1111, on_tick);
    wait_ticks(3);

    load(16'hFFFF, 4'b0000, 4'b0000, on_tick);
    wait_ticks(3);
    load(16'h1111, 4'b0000, 4'b0001, on_tick);
    wait_ticks(3);

    load(16'h4321, 4'b0100, 4'b1111, on_tick);
    found = 1'b0;
    for (int c = 0; c < 64 * SCAN_DIV && !found; c++) begin
      @(negedge clk);
      if (sel == 4'hB) found = 1'b1;
    end
    check("reach_digit2", found, 1'b1);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check_reset("mid_rst");
    @(posedge clk); #1 rst = 1'b0;
    wait_ticks(2);
    check("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
